// File: rtl/gray_ts_sched.sv
// gray_ts_sched: runs the gray counter arm/run/stop sequence, round-robin grants one channel per cycle, queues {epoch, ch_id, gray} stamps.
// Latency: a stamp is on ts_data the cycle after selection; ch_ack is registered and appears in that same cycle.
// Backpressure: ts_ready stalls the FWFT FIFO; a full FIFO with no pop blocks grants and sets the sticky ovf flag.
module gray_ts_sched #(
  parameter int  N_CH       = 4,
  parameter int  CNT_W      = 16,
  parameter int  EPOCH_W    = 8,
  parameter int  FIFO_DEPTH = 4,
  parameter int  ARM_CYC    = 2,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int TS_W       = EPOCH_W + CH_W + CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] gray_in,
  output logic             cnt_rstb,
  input  logic [N_CH-1:0]  ch_req,
  output logic [N_CH-1:0]  ch_ack,
  output logic [TS_W-1:0]  ts_data,
  output logic             ts_valid,
  input  logic             ts_ready,
  output logic             busy,
  output logic             ovf
);

  // FIFO_DEPTH is a power of two, at least 2; pointers carry one extra wrap bit.
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int AW = $clog2(ARM_CYC + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [AW-1:0]      arm_cnt_q, arm_cnt_d;
  logic               cnt_rstb_q;
  logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [N_CH-1:0]    ack_q, ack_d;
  logic               ovf_q, ovf_d;
  logic               msb_q;
  logic [EPOCH_W-1:0] epoch_q, epoch_d, epoch_now;
  logic [TS_W-1:0]    mem_q [FIFO_DEPTH];
  logic [PW:0]        wr_ptr_q, rd_ptr_q;

  logic               empty, full, pop, push, space, tracking, wrap, start_ok;
  logic [N_CH-1:0]    req_m, req_rot;
  logic [2*N_CH-1:0]  req_dbl;
  logic               gnt_found;
  logic [CH_W-1:0]    gnt_idx;
  logic [CH_W:0]      idx_sum;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q == {~rd_ptr_q[PW], rd_ptr_q[PW-1:0]});
  assign pop       = ~empty & ts_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign space     = ~full | pop;
  assign tracking  = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign wrap      = tracking & msb_q & ~gray_in[CNT_W-1];
  // A stamp taken in the wrap cycle must already carry the incremented epoch.
  assign epoch_now = epoch_q + EPOCH_W'(wrap);
  assign push      = (state_q == S_RUN) & ~stop & gnt_found & space;
  assign start_ok  = (state_q == S_IDLE) & start;

  // Round-robin pick: rotate the masked requests so rr_ptr sits at bit 0, take the lowest set bit.
  always_comb begin
    req_m     = ch_req & ~ack_q;
    req_dbl   = {req_m, req_m} >> rr_ptr_q;
    req_rot   = req_dbl[N_CH-1:0];
    gnt_found = 1'b0;
    idx_sum   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        gnt_found = 1'b1;
        idx_sum   = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
      end
    end
    if (idx_sum >= (CH_W+1)'(N_CH)) begin
      idx_sum = idx_sum - (CH_W+1)'(N_CH);
    end
    gnt_idx = idx_sum[CH_W-1:0];
  end

  // Sequencer: IDLE -> ARM (counter held in reset) -> RUN -> DRAIN -> IDLE.
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ARM;
          arm_cnt_d = '0;
        end
      end
      S_ARM: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (arm_cnt_q == AW'(ARM_CYC - 1)) begin
          state_d = S_RUN;
        end else begin
          arm_cnt_d = arm_cnt_q + AW'(1);
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (empty) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grant, round-robin pointer, sticky overflow and epoch next-state.
  always_comb begin
    ack_d    = push ? (N_CH'(1) << gnt_idx) : '0;
    rr_ptr_d = rr_ptr_q;
    if (start_ok) begin
      rr_ptr_d = '0;
    end else if (push) begin
      rr_ptr_d = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
    end
    ovf_d   = start_ok ? 1'b0 : (ovf_q | ((state_q == S_RUN) & (|req_m) & ~space));
    epoch_d = start_ok ? '0 : (tracking ? epoch_now : epoch_q);
  end

  // Control and status registers; async reset forces every output to idle values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      arm_cnt_q  <= '0;
      cnt_rstb_q <= 1'b0;
      rr_ptr_q   <= '0;
      ack_q      <= '0;
      ovf_q      <= 1'b0;
      msb_q      <= 1'b0;
      epoch_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      cnt_rstb_q <= (state_d == S_RUN) | (state_d == S_DRAIN);
      rr_ptr_q   <= rr_ptr_d;
      ack_q      <= ack_d;
      ovf_q      <= ovf_d;
      msb_q      <= gray_in[CNT_W-1];
      epoch_q    <= epoch_d;
      if (push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
    end
  end

  // Stamp storage; the raw gray value is stored unconverted.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= {epoch_now, gnt_idx, gray_in};
  end

  assign cnt_rstb = cnt_rstb_q;
  assign ch_ack   = ack_q;
  assign ts_valid = ~empty;
  assign ts_data  = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];
  assign busy     = (state_q != S_IDLE);
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_gray_ts_sched.sv
`timescale 1ns/1ps
// tb_gray_ts_sched: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_gray_ts_sched;
  localparam int N_CH = 4;
  localparam int DEPTH = 4;
  localparam int ARM_CYC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        ts_ready = 1'b0;
  logic [15:0] gray_in = '0;
  logic [3:0]  ch_req = '0;
  logic        cnt_rstb, ts_valid, busy, ovf;
  logic [3:0]  ch_ack;
  logic [25:0] ts_data;

  int checks = 0;
  int failures = 0;

  gray_ts_sched #(.N_CH(4), .CNT_W(16), .EPOCH_W(8), .FIFO_DEPTH(4), .ARM_CYC(2)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .gray_in(gray_in),
    .cnt_rstb(cnt_rstb), .ch_req(ch_req), .ch_ack(ch_ack), .ts_data(ts_data),
    .ts_valid(ts_valid), .ts_ready(ts_ready), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference model: state as plain ints, FIFO as a queue of stamps.
  localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_DRAIN = 3;
  int          m_state, m_arm, m_epoch, m_rr, m_ack;
  bit          m_ovf, m_msb;
  logic [25:0] m_q[$];
  bit          gray_manual = 1'b0;
  int unsigned bin = 0;

  function automatic logic [3:0] exp_ack();
    return (m_ack < 0) ? 4'd0 : 4'(1 << m_ack);
  endfunction

  function automatic logic [25:0] exp_data();
    return (m_q.size() == 0) ? 26'd0 : m_q[0];
  endfunction

  function automatic logic [15:0] g2b(input logic [15:0] g);
    logic [15:0] b;
    b[15] = g[15];
    for (int i = 14; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_arm = 0; m_epoch = 0; m_rr = 0; m_ack = -1;
    m_ovf = 1'b0; m_msb = 1'b0; m_q.delete();
  endtask

  task automatic model_step();
    int qn, win, c, ep_now;
    bit do_pop, space, wrap, anyreq;
    qn = m_q.size();
    do_pop = (qn != 0) && ts_ready;
    space = (qn < DEPTH) || do_pop;
    wrap = (m_state == M_RUN || m_state == M_DRAIN) && m_msb && !gray_in[15];
    ep_now = (m_epoch + (wrap ? 1 : 0)) % 256;
    anyreq = 1'b0;
    for (int i = 0; i < N_CH; i++) if (ch_req[i] && i != m_ack) anyreq = 1'b1;
    win = -1;
    if (m_state == M_RUN && !stop && space) begin
      for (int k = 0; k < N_CH; k++) begin
        c = (m_rr + k) % N_CH;
        if (win < 0 && ch_req[c] && c != m_ack) win = c;
      end
    end
    if (do_pop) void'(m_q.pop_front());
    if (m_state == M_RUN && anyreq && !space) m_ovf = 1'b1;
    m_ack = -1;
    if (win >= 0) begin
      m_q.push_back({8'(ep_now), 2'(win), gray_in});
      m_ack = win;
      m_rr = (win + 1) % N_CH;
    end
    if (m_state == M_RUN || m_state == M_DRAIN) m_epoch = ep_now;
    m_msb = gray_in[15];
    case (m_state)
      M_IDLE:  if (start) begin m_state = M_ARM; m_arm = 0; m_epoch = 0; m_ovf = 1'b0; m_rr = 0; end
      M_ARM:   if (stop) m_state = M_IDLE; else begin m_arm++; if (m_arm == ARM_CYC) m_state = M_RUN; end
      M_RUN:   if (stop) m_state = M_DRAIN;
      default: if (qn == 0) m_state = M_IDLE;
    endcase
  endtask

  // One clock: advance the model with the current inputs, then step the DUT; counter tracks cnt_rstb.
  task automatic tick();
    int prev_state;
    prev_state = m_state;
    model_step();
    @(posedge clk); #1;
    if (!gray_manual) begin
      if (prev_state == M_RUN || prev_state == M_DRAIN) bin = (bin + 1) & 32'hFFFF; else bin = 0;
      gray_in = 16'(bin ^ (bin >> 1));
    end
  endtask

  task automatic restart();
    if (m_state != M_IDLE) begin
      stop = 1'b1; tick(); stop = 1'b0; ts_ready = 1'b1;
      for (int i = 0; i < 20 && m_state != M_IDLE; i++) tick();
    end
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; model_reset(); bin = 0; gray_in = '0; #3;
    checks++; if (cnt_rstb !== 1'b0) begin failures++; $display("FAIL reset_cnt_rstb got=%b want=0", cnt_rstb); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (ts_valid !== 1'b0) begin failures++; $display("FAIL reset_ts_valid got=%b want=0", ts_valid); end
    checks++; if (ch_ack !== 4'd0 || ovf !== 1'b0 || ts_data !== 26'd0) begin
      failures++; $display("FAIL reset_misc ack=%b ovf=%b data=%h want 0/0/0", ch_ack, ovf, ts_data); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_arm();
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (cnt_rstb !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL arm_c1 cnt_rstb=%b busy=%b want 0/1", cnt_rstb, busy); end
    tick();
    checks++; if (cnt_rstb !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL arm_c2 cnt_rstb=%b busy=%b want 0/1", cnt_rstb, busy); end
    tick();
    checks++; if (cnt_rstb !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL arm_run cnt_rstb=%b busy=%b want 1/1", cnt_rstb, busy); end
  endtask

  task automatic test_rotate();
    int n, prev, cur;
    ch_req = 4'b1111; ts_ready = 1'b1;
    n = 0;
    while (ch_ack == 4'd0 && n < 4) begin tick(); n++; end
    checks++; if (ch_ack == 4'd0) begin failures++; $display("FAIL rot_first_ack got=%b want nonzero within 4 cycles", ch_ack); end
    prev = -1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (ch_ack !== 4'(1 << (k % 4))) begin failures++; $display("FAIL rot_ack[%0d] got=%b want=%b", k, ch_ack, 4'(1 << (k % 4))); end
      checks++; if (ts_valid !== 1'b1 || ts_data[17:16] !== 2'(k % 4)) begin
        failures++; $display("FAIL rot_chid[%0d] valid=%b ch=%0d want 1/%0d", k, ts_valid, ts_data[17:16], k % 4); end
      checks++; if (ts_data !== exp_data()) begin failures++; $display("FAIL rot_data[%0d] got=%h want=%h", k, ts_data, exp_data()); end
      cur = int'(g2b(ts_data[15:0]));
      checks++; if (cur <= prev) begin failures++; $display("FAIL rot_gray_inc[%0d] got=%0d want>%0d", k, cur, prev); end
      prev = cur;
      tick();
    end
    ch_req = 4'd0; tick(); tick();
  endtask

  task automatic test_overflow();
    int acks;
    ch_req = 4'b0001; ts_ready = 1'b0; acks = 0;
    for (int i = 0; i < 16; i++) begin tick(); if (ch_ack[0]) acks++; end
    checks++; if (acks != 4) begin failures++; $display("FAIL ovf_ack_count got=%0d want=4", acks); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b want=1", ovf); end
    checks++; if (ts_valid !== 1'b1 || ts_data !== exp_data()) begin
      failures++; $display("FAIL ovf_head valid=%b data=%h want 1/%h", ts_valid, ts_data, exp_data()); end
    ts_ready = 1'b1; tick();
    checks++; if (ch_ack !== 4'b0001) begin failures++; $display("FAIL ovf_resume_ack got=%b want=0001", ch_ack); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b want=1", ovf); end
    ch_req = 4'd0;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (ts_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained valid=%b want=0", ts_valid); end
  endtask

  task automatic test_wrap();
    logic [25:0] want;
    restart();
    gray_manual = 1'b1; ts_ready = 1'b0; ch_req = 4'd0;
    gray_in = 16'h8000; tick();
    gray_in = 16'h0000; ch_req = 4'b0100; tick(); ch_req = 4'd0;
    want = {8'd1, 2'd2, 16'h0000};
    checks++; if (ts_valid !== 1'b1 || ts_data !== want) begin failures++; $display("FAIL wrap_stamp got=%h want=%h", ts_data, want); end
    checks++; if (ch_ack !== 4'b0100) begin failures++; $display("FAIL wrap_ack got=%b want=0100", ch_ack); end
    ts_ready = 1'b1; tick(); ts_ready = 1'b0;
    for (int i = 0; i < 254; i++) begin gray_in = 16'h8000; tick(); gray_in = 16'h0000; tick(); end
    gray_in = 16'h0100; ch_req = 4'b0010; tick(); ch_req = 4'd0;
    want = {8'd255, 2'd1, 16'h0100};
    checks++; if (ts_data !== want) begin failures++; $display("FAIL wrap_255 got=%h want=%h", ts_data, want); end
    ts_ready = 1'b1; tick(); ts_ready = 1'b0;
    gray_in = 16'h8000; tick(); gray_in = 16'h0000; tick();
    gray_in = 16'h1234; ch_req = 4'b1000; tick(); ch_req = 4'd0;
    want = {8'd0, 2'd3, 16'h1234};
    checks++; if (ts_data !== want) begin failures++; $display("FAIL wrap_256 got=%h want=%h", ts_data, want); end
    ts_ready = 1'b1; tick();
    gray_manual = 1'b0;
  endtask

  task automatic test_stop_drain();
    int acks, pops, n;
    ts_ready = 1'b0; ch_req = 4'b0111;
    tick(); tick(); tick();
    ch_req = 4'd0; tick();
    checks++; if (ts_valid !== 1'b1 || ts_data !== exp_data()) begin
      failures++; $display("FAIL drain_pre valid=%b data=%h want 1/%h", ts_valid, ts_data, exp_data()); end
    ch_req = 4'b1111; stop = 1'b1; tick(); stop = 1'b0; ts_ready = 1'b1;
    acks = 0; pops = 0; n = 0;
    while (busy === 1'b1 && n < 20) begin
      if (ch_ack != 4'd0) acks++;
      if (ts_valid && ts_ready) pops++;
      tick(); n++;
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drain_idle busy=%b want=0 within 20 cycles", busy); end
    checks++; if (acks != 0) begin failures++; $display("FAIL drain_no_ack got=%0d want=0", acks); end
    checks++; if (pops != 3) begin failures++; $display("FAIL drain_pops got=%0d want=3", pops); end
    checks++; if (cnt_rstb !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL drain_end cnt_rstb=%b ovf=%b want 0/0", cnt_rstb, ovf); end
    ch_req = 4'd0;
  endtask

  task automatic test_reset_mid_run();
    restart();
    ts_ready = 1'b0; ch_req = 4'b0011; tick(); tick();
    checks++; if (ts_valid !== 1'b1 || ch_ack !== exp_ack()) begin
      failures++; $display("FAIL mid_pre valid=%b ack=%b want 1/%b", ts_valid, ch_ack, exp_ack()); end
    #2 reset = 1'b0; #1;
    checks++; if (ts_valid !== 1'b0 || ts_data !== 26'd0) begin failures++; $display("FAIL mid_fifo valid=%b data=%h want 0/0", ts_valid, ts_data); end
    checks++; if (ch_ack !== 4'd0 || busy !== 1'b0 || cnt_rstb !== 1'b0 || ovf !== 1'b0) begin
      failures++; $display("FAIL mid_ctrl ack=%b busy=%b cnt_rstb=%b ovf=%b want all 0", ch_ack, busy, cnt_rstb, ovf); end
    model_reset(); ch_req = 4'd0;
    @(negedge clk); reset = 1'b1;
    tick();
    checks++; if (ts_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_after valid=%b busy=%b want 0/0", ts_valid, busy); end
  endtask

  task automatic test_random();
    int ready_pct;
    logic [3:0] req;
    restart();
    ready_pct = 70; req = 4'd0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc % 100 == 0) ready_pct = $urandom_range(10, 100);
      start = ($urandom_range(0, 39) == 0);
      stop = ($urandom_range(0, 69) == 0);
      ts_ready = ($urandom_range(1, 100) <= ready_pct);
      for (int i = 0; i < N_CH; i++) begin
        if (ch_ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      end
      ch_req = req;
      if (m_state == M_RUN && $urandom_range(0, 149) == 0) begin
        bin = 32'hFFF8; gray_in = 16'(bin ^ (bin >> 1));
      end
      tick();
      checks++; if (ch_ack !== exp_ack()) begin failures++; $display("FAIL rnd_ack@%0d got=%b want=%b", cyc, ch_ack, exp_ack()); end
      checks++; if (ts_valid !== (m_q.size() != 0)) begin failures++; $display("FAIL rnd_valid@%0d got=%b want=%b", cyc, ts_valid, m_q.size() != 0); end
      checks++; if (ts_data !== exp_data()) begin failures++; $display("FAIL rnd_data@%0d got=%h want=%h", cyc, ts_data, exp_data()); end
      checks++; if (ovf !== m_ovf) begin failures++; $display("FAIL rnd_ovf@%0d got=%b want=%b", cyc, ovf, m_ovf); end
      checks++; if (busy !== (m_state != M_IDLE)) begin failures++; $display("FAIL rnd_busy@%0d got=%b want=%b", cyc, busy, m_state != M_IDLE); end
      checks++; if (cnt_rstb !== (m_state == M_RUN || m_state == M_DRAIN)) begin
        failures++; $display("FAIL rnd_cnt_rstb@%0d got=%b want=%b", cyc, cnt_rstb, m_state == M_RUN || m_state == M_DRAIN); end
    end
    start = 1'b0; stop = 1'b0; ch_req = 4'd0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_arm();
    test_rotate();
    test_overflow();
    test_wrap();
    test_stop_drain();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
